bep_frame_capture: RTL and testbench
====================================

Name: bep_frame_capture

Overview:
Parametrised successor of the BEP byte-readout path. Oversamples the BEP serial_clock/serial_data pair in the system clock domain and assembles FRAME_BYTES-byte frames. Commits each complete frame to a shadow buffer that the microcontroller reads byte-wise by address. Adds what the previous block lacked: a host hold (RX freeze during readout), a valid/ack handshake, overrun flagging, and an inter-frame gap timeout.

Parameters:
FRAME_BYTES, 12, bytes per BEP frame (>=1).
ADDR_W, 4, address width; 2**ADDR_W >= FRAME_BYTES (+2 when BEP_FRAME_STATS_EN).
GAP_CYCLES, 1024, idle clk cycles without a serial_clock rising edge that abort a partial frame (>=4).
SYNC_STAGES, 2, synchroniser depth for serial_clock and serial_data (>=2).

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
serial_clock  in  1  async BEP bit clock; data sampled on its rising edge.
serial_data  in  1  async BEP data.
hold  in  1  1 = freeze shadow buffer; frames completing while high are dropped.
ack  in  1  single-cycle pulse: host has consumed the frame; clears full and overrun.
address  in  ADDR_W  byte select for readout.
parallel_out  out  8  registered shadow byte at address.
full  out  1  unread frame present in the shadow buffer.
overrun  out  1  sticky; a frame was lost or overwritten since the last ack.

Behaviour:
- Reset (clk edge with reset=1): parallel_out=0, full=0, overrun=0, bit counter=0, gap counter=0, shift and shadow registers=0, synchronisers=0, stats=0. Reset mid-frame discards the partial frame.
- Sync: serial_clock and serial_data each pass through SYNC_STAGES flops in parallel, so they stay aligned. A rising edge is previous synced clock=0 and current synced clock=1. At that edge, synced data is the sampled bit. Input-to-sample latency is SYNC_STAGES+1 clk.
- Bit order: received bit n (n=0 first) lands in byte n/8, bit n%8 (LSB-first, byte 0 first). Implement as a right shift with the new bit entering the MSB of the FRAME_BYTES*8 vector.
- Counters: the bit counter increments per sampled bit. The gap counter clears on each edge and increments otherwise, saturating at GAP_CYCLES. On reaching GAP_CYCLES with bit counter !=0, the bit counter returns to 0; the partial frame is silently discarded and no flag is set.
- Commit: on the sample that makes bit count = FRAME_BYTES*8, the bit counter returns to 0 that same cycle.
  - If hold=0, the shift vector is copied to the shadow buffer on the next clk edge and full=1. If full was already 1, the shadow is overwritten and overrun=1.
  - If hold=1, the shadow is untouched, the frame is dropped, overrun=1, and full is unchanged.
- ack: clears full and overrun next cycle.
  - ack in the same cycle as a commit: full=1, overrun=0 (the commit counts against a freshly emptied buffer).
  - ack in the same cycle as a hold-drop: overrun=1.
- Readout: parallel_out <= shadow byte[address] every cycle, giving 1-cycle latency.
  - address >= FRAME_BYTES reads 0, except stats addresses (see the Optional Feature section).
  - Shadow updates are visible on the cycle after the commit edge.
- hold does not stall reception: shifting continues. Only the commit is suppressed.

Optional Feature:
Macro BEP_FRAME_STATS_EN.
- Defined: two 8-bit wrapping counters, readable at address FRAME_BYTES (committed frames) and FRAME_BYTES+1 (dropped or overwritten frames, i.e. each event that sets overrun). A gap abort increments neither. Both are cleared by reset only, not by ack.
- Undefined: counters absent; those addresses read 0.

Decomposition:
- Shared package bep_pkg: BEP_FRAME_BYTES_DEFAULT=12, stats address offsets, and the byte-index constants for the frame fields. The field constants are ID 0..3, room temp 4..5, set temp 6..7, state 8, tail 9..11, so firmware and bench share one map.
- One sub-module, bep_edge_sync: SYNC_STAGES synchroniser for clock+data with rising-edge strobe and aligned data output.

Test Plan:
1. Reset, then send 96 bits encoding bytes 0x00..0x0B LSB-first, hold=0 → full=1 within SYNC_STAGES+2 clk of the last edge; address 0..11 reads 0x00..0x0B one cycle after each address change; address 12 reads 0x00.
2. Send 40 bits, idle GAP_CYCLES+5 clk, then a full 96-bit frame of 0xA5 → shadow all 0xA5; no bit misalignment; overrun=0.
3. Two frames with no ack → second frame visible; full=1, overrun=1; then ack pulse → full=0, overrun=0 next cycle.
4. hold=1 during the completion of frame 2 (frame 1 = 0x11s, frame 2 = 0x22s) → reads stay 0x11; overrun=1. Release hold and send frame 3 = 0x33s → reads 0x33.
5. ack asserted in the exact commit cycle → full=1, overrun=0. Assert reset mid-frame (bit 50) → all outputs 0; next complete frame is captured correctly.
6. With BEP_FRAME_STATS_EN, run 3 commits plus 1 hold-drop → address 12 reads 3, address 13 reads 1. Then 256 further commits → address 12 wraps to 3.

Source files
------------

// File: rtl/bep_pkg.sv
// Shared constants for the BEP frame capture block and its firmware/bench users.
// Holds the default frame length, the offsets of the statistics bytes past the
// frame, and the byte map of the fields inside a BEP frame.
package bep_pkg;

    localparam int BEP_FRAME_BYTES_DEFAULT = 12;

    // Statistics bytes sit directly after the frame bytes in the read map
    localparam int BEP_STATS_COMMIT_OFFSET = 0;
    localparam int BEP_STATS_DROP_OFFSET   = 1;

    // Byte indices of the fields inside a frame
    localparam int BEP_ID_FIRST        = 0;
    localparam int BEP_ID_LAST         = 3;
    localparam int BEP_ROOM_TEMP_FIRST = 4;
    localparam int BEP_ROOM_TEMP_LAST  = 5;
    localparam int BEP_SET_TEMP_FIRST  = 6;
    localparam int BEP_SET_TEMP_LAST   = 7;
    localparam int BEP_STATE_BYTE      = 8;
    localparam int BEP_TAIL_FIRST      = 9;
    localparam int BEP_TAIL_LAST       = 11;

endpackage

// File: rtl/bep_edge_sync.sv
// Synchroniser for the BEP serial clock/data pair.
// Both lines run through identical flop chains so the data bit seen at a
// detected rising edge is the one that was present with that edge.
module bep_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic serial_clock,
    input  logic serial_data,
    output logic sample_strobe,
    output logic sample_bit
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;

    // Shift both async inputs through parallel chains and remember the last synced clock
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= '0;
            dat_sync <= '0;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], serial_clock};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], serial_data};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign sample_strobe = clk_sync[SYNC_STAGES-1] & ~clk_prev;
    assign sample_bit    = dat_sync[SYNC_STAGES-1];

endmodule

// File: rtl/bep_frame_capture.sv
// BEP frame capture: assembles LSB-first serial frames, commits them to a
// shadow buffer read byte-wise by the host, with hold, ack, overrun and an
// inter-frame gap timeout that throws away partial frames.
// Optional macro BEP_FRAME_STATS_EN adds committed/overrun frame counters
// readable just past the frame bytes.
module bep_frame_capture
    import bep_pkg::*;
#(
    parameter int FRAME_BYTES = BEP_FRAME_BYTES_DEFAULT,
    parameter int ADDR_W      = 4,
    parameter int GAP_CYCLES  = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_clock,
    input  logic              serial_data,
    input  logic              hold,
    input  logic              ack,
    input  logic [ADDR_W-1:0] address,
    output logic [7:0]        parallel_out,
    output logic              full,
    output logic              overrun
);

    localparam int FRAME_BITS = FRAME_BYTES * 8;
    localparam int BIT_W      = $clog2(FRAME_BITS + 1);
    localparam int GAP_W      = $clog2(GAP_CYCLES + 1);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    logic                  sample_strobe;
    logic                  sample_bit;
    logic [BIT_W-1:0]      bit_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] shadow;
    logic                  frame_done;
    logic                  commit_ok;
    logic                  drop_evt;
    logic                  overrun_evt;
    logic [7:0]            rd_byte;

    bep_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk           (clk),
        .reset         (reset),
        .serial_clock  (serial_clock),
        .serial_data   (serial_data),
        .sample_strobe (sample_strobe),
        .sample_bit    (sample_bit)
    );

    // Shift in sampled bits, count them, flag a complete frame and abort stale partial frames
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            shift_reg  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (sample_strobe) begin
                gap_cnt   <= '0;
                shift_reg <= {sample_bit, shift_reg[FRAME_BITS-1:1]};
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else begin
                if (gap_cnt != GAP_MAX) begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                if ((gap_cnt == GAP_LAST) && (bit_cnt != '0)) begin
                    bit_cnt <= '0;
                end
            end
        end
    end

    // A finished frame either commits (hold low) or is dropped; overwriting an unread frame is also a loss
    always_comb begin
        commit_ok   = frame_done & ~hold;
        drop_evt    = frame_done & hold;
        overrun_evt = drop_evt | (commit_ok & full & ~ack);
    end

    // Shadow buffer and host status flags; a commit wins over an ack in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow  <= '0;
            full    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (commit_ok) begin
                shadow <= shift_reg;
            end
            if (commit_ok) begin
                full <= 1'b1;
            end else if (ack) begin
                full <= 1'b0;
            end
            if (overrun_evt) begin
                overrun <= 1'b1;
            end else if (ack) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef BEP_FRAME_STATS_EN
    logic [7:0] stat_commits;
    logic [7:0] stat_drops;

    // Wrapping frame statistics, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_commits <= 8'h00;
            stat_drops   <= 8'h00;
        end else begin
            if (commit_ok) begin
                stat_commits <= stat_commits + 8'h01;
            end
            if (overrun_evt) begin
                stat_drops <= stat_drops + 8'h01;
            end
        end
    end
`endif

    // Select the addressed byte; anything outside the frame (and stats, if present) reads zero
    always_comb begin
        rd_byte = 8'h00;
        for (int i = 0; i < FRAME_BYTES; i++) begin
            if (int'(address) == i) begin
                rd_byte = shadow[i*8 +: 8];
            end
        end
`ifdef BEP_FRAME_STATS_EN
        if (int'(address) == FRAME_BYTES + BEP_STATS_COMMIT_OFFSET) begin
            rd_byte = stat_commits;
        end
        if (int'(address) == FRAME_BYTES + BEP_STATS_DROP_OFFSET) begin
            rd_byte = stat_drops;
        end
`endif
    end

    // Registered readout gives the host a fixed one-cycle address-to-data latency
    always_ff @(posedge clk) begin
        if (reset) begin
            parallel_out <= 8'h00;
        end else begin
            parallel_out <= rd_byte;
        end
    end

endmodule

// File: tb/tb_bep_frame_capture.sv
// Directed bench for bep_frame_capture with a byte-readout scoreboard and a
// small host-side model of shadow contents, full/overrun and statistics.
// Honours BEP_FRAME_STATS_EN for the statistics checks.
module tb_bep_frame_capture;
    import bep_pkg::*;

    localparam int FB    = BEP_FRAME_BYTES_DEFAULT;
    localparam int AW    = 4;
    localparam int GAP   = 64;
    localparam int SYNC  = 2;
    localparam int FBITS = FB * 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          serial_clock;
    logic          serial_data;
    logic          hold;
    logic          ack;
    logic [AW-1:0] address;
    logic [7:0]    parallel_out;
    logic          full;
    logic          overrun;

    bep_frame_capture #(
        .FRAME_BYTES (FB),
        .ADDR_W      (AW),
        .GAP_CYCLES  (GAP),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_clock (serial_clock),
        .serial_data  (serial_data),
        .hold         (hold),
        .ack          (ack),
        .address      (address),
        .parallel_out (parallel_out),
        .full         (full),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];

    logic [7:0] m_shadow[FB];
    logic       m_full;
    logic       m_overrun;
    logic [7:0] m_commits;
    logic [7:0] m_drops;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        serial_data  = b;
        serial_clock = 1'b0;
        @(negedge clk);
        serial_clock = 1'b1;
    endtask

    task automatic applyStimulus(input logic [FBITS-1:0] vec, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            send_bit(vec[i]);
        end
    endtask

    function automatic logic [FBITS-1:0] fill_frame(input logic [7:0] v);
        logic [FBITS-1:0] f;
        for (int i = 0; i < FB; i++) f[i*8 +: 8] = v;
        return f;
    endfunction

    function automatic logic [FBITS-1:0] seq_frame();
        logic [FBITS-1:0] f;
        for (int i = 0; i < FB; i++) f[i*8 +: 8] = 8'(i);
        return f;
    endfunction

    function automatic logic [FBITS-1:0] field_frame();
        logic [FBITS-1:0] f;
        for (int i = 0; i < FB; i++) begin
            if (i <= BEP_ID_LAST)             f[i*8 +: 8] = 8'hB0 + 8'(i);
            else if (i <= BEP_ROOM_TEMP_LAST) f[i*8 +: 8] = 8'h40 + 8'(i);
            else if (i <= BEP_SET_TEMP_LAST)  f[i*8 +: 8] = 8'h60 + 8'(i);
            else if (i == BEP_STATE_BYTE)     f[i*8 +: 8] = 8'h5C;
            else                              f[i*8 +: 8] = 8'hE0 + 8'(i);
        end
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < FB; i++) m_shadow[i] = 8'h00;
        m_full    = 1'b0;
        m_overrun = 1'b0;
        m_commits = 8'h00;
        m_drops   = 8'h00;
    endtask

    task automatic model_frame(input logic [FBITS-1:0] vec, input logic hold_now, input logic ack_now);
        if (hold_now) begin
            m_overrun = 1'b1;
            m_drops++;
            if (ack_now) m_full = 1'b0;
        end else begin
            if (m_full && !ack_now) begin
                m_overrun = 1'b1;
                m_drops++;
            end else if (ack_now) begin
                m_overrun = 1'b0;
            end
            for (int i = 0; i < FB; i++) m_shadow[i] = vec[i*8 +: 8];
            m_full = 1'b1;
            m_commits++;
        end
    endtask

    function automatic logic [7:0] exp_byte(input int a);
        logic [7:0] r = 8'h00;
        if (a < FB) r = m_shadow[a];
`ifdef BEP_FRAME_STATS_EN
        if (a == FB + BEP_STATS_COMMIT_OFFSET) r = m_commits;
        if (a == FB + BEP_STATS_DROP_OFFSET)   r = m_drops;
`endif
        return r;
    endfunction

    task automatic read_sweep(input string tag);
        for (int a = 0; a < FB + 2; a++) begin
            @(negedge clk);
            address = AW'(a);
            exp_q.push_back(exp_byte(a));
            tag_q.push_back($sformatf("%s_addr%0d", tag, a));
            @(negedge clk);
            checkOutput(tag_q.pop_front(), 32'(parallel_out), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic check_flags(input string tag);
        checkOutput({tag, "_full"}, 32'(full), 32'(m_full));
        checkOutput({tag, "_overrun"}, 32'(overrun), 32'(m_overrun));
    endtask

    task automatic finish_frame();
        repeat (SYNC + 2) @(negedge clk);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        m_full    = 1'b0;
        m_overrun = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        serial_clock = 1'b0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        checkOutput({tag, "_parallel_out"}, 32'(parallel_out), 32'h0);
        check_flags(tag);
        reset = 1'b0;
    endtask

    initial begin
        logic [FBITS-1:0] v;
        reset        = 1'b1;
        serial_clock = 1'b0;
        serial_data  = 1'b0;
        hold         = 1'b0;
        ack          = 1'b0;
        address      = '0;
        model_reset();

        do_reset("reset");

        $display("[TB] test 1: sequential frame and readout latency");
        v = seq_frame();
        applyStimulus(v, FBITS);
        repeat (SYNC + 1) @(negedge clk);
        checkOutput("t1_full_before_commit", 32'(full), 32'h0);
        @(negedge clk);
        model_frame(v, 1'b0, 1'b0);
        check_flags("t1");
        read_sweep("t1");

        $display("[TB] test 2: gap timeout discards partial frame");
        pulse_ack();
        check_flags("t2_ack");
        applyStimulus(fill_frame(8'hFF), 40);
        repeat (GAP + 5) @(negedge clk);
        v = fill_frame(8'hA5);
        applyStimulus(v, FBITS);
        finish_frame();
        model_frame(v, 1'b0, 1'b0);
        check_flags("t2");
        read_sweep("t2");

        $display("[TB] test 3: overwrite without ack");
        pulse_ack();
        v = fill_frame(8'h5A);
        applyStimulus(v, FBITS);
        finish_frame();
        model_frame(v, 1'b0, 1'b0);
        v = fill_frame(8'hC3);
        applyStimulus(v, FBITS);
        finish_frame();
        model_frame(v, 1'b0, 1'b0);
        check_flags("t3");
        read_sweep("t3");
        pulse_ack();
        check_flags("t3_ack");

        $display("[TB] test 4: hold drops a frame");
        v = fill_frame(8'h11);
        applyStimulus(v, FBITS);
        finish_frame();
        model_frame(v, 1'b0, 1'b0);
        pulse_ack();
        @(negedge clk);
        hold = 1'b1;
        v = fill_frame(8'h22);
        applyStimulus(v, FBITS);
        finish_frame();
        model_frame(v, 1'b1, 1'b0);
        @(negedge clk);
        hold = 1'b0;
        check_flags("t4_hold");
        read_sweep("t4_hold");
        v = fill_frame(8'h33);
        applyStimulus(v, FBITS);
        finish_frame();
        model_frame(v, 1'b0, 1'b0);
        check_flags("t4_release");
        read_sweep("t4_release");

        $display("[TB] test 5: ack in commit cycle, reset mid-frame");
        v = fill_frame(8'h77);
        applyStimulus(v, FBITS);
        repeat (SYNC + 1) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        model_frame(v, 1'b0, 1'b1);
        check_flags("t5_ack_commit");
        read_sweep("t5_ack_commit");
        applyStimulus(fill_frame(8'hEE), 50);
        do_reset("t5_reset");
        v = field_frame();
        applyStimulus(v, FBITS);
        finish_frame();
        model_frame(v, 1'b0, 1'b0);
        check_flags("t5_after_reset");
        read_sweep("t5_after_reset");

`ifdef BEP_FRAME_STATS_EN
        $display("[TB] test 6: statistics counters");
        do_reset("t6_reset");
        for (int i = 0; i < 3; i++) begin
            v = fill_frame(8'(i + 1));
            applyStimulus(v, FBITS);
            finish_frame();
            model_frame(v, 1'b0, 1'b0);
            pulse_ack();
        end
        @(negedge clk);
        hold = 1'b1;
        v = fill_frame(8'hEE);
        applyStimulus(v, FBITS);
        finish_frame();
        model_frame(v, 1'b1, 1'b0);
        @(negedge clk);
        hold = 1'b0;
        read_sweep("t6_stats");
        pulse_ack();
        for (int i = 0; i < 256; i++) begin
            v = fill_frame(8'(i));
            applyStimulus(v, FBITS);
            finish_frame();
            model_frame(v, 1'b0, 1'b0);
            pulse_ack();
        end
        read_sweep("t6_wrap");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
